// File: rtl/rv_pkg.sv
// Shared fetch-stage definitions: canonical NOP, default boot PC and fetch FSM encoding.
package rv_pkg;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_TRAP = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response, decode handshake, execute redirect.
interface if_fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_valid;
  logic        id_misalign;

  modport master (
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, id_misalign,
    input  imem_rdata, stall, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, id_misalign,
    output imem_rdata, stall, redirect_valid, redirect_target
  );
endinterface

// File: rtl/if_fetch_stage.sv
// PC generator / fetch stage in front of a 1-cycle synchronous imem; the imem output
// register doubles as the IF/ID instruction register.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = rv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = rv_pkg::NOP_INSTR
) (
  input  logic                    clk,
  input  logic                    rst,
  if_fetch_stage_if.master        bus,
  output logic [31:0]             fetch_count
);

  rv_pkg::fetch_state_t state, state_nxt;
  logic [31:0] pc_fetch, pc_fetch_nxt;
  logic [31:0] pc_resp, pc_resp_nxt;
  logic        resp_valid, resp_valid_nxt;
  logic        misalign_q, misalign_nxt;
  logic [31:0] count_nxt;

  logic redir_take, redir_mis;
  assign redir_take = bus.redirect_valid && (state != rv_pkg::S_BOOT);
  assign redir_mis  = |bus.redirect_target[1:0];

  // Address mux and next-state logic. A redirect overrides stall so the target word
  // is read this cycle and shown next cycle with no bubble.
  always_comb begin
    state_nxt      = state;
    pc_fetch_nxt   = pc_fetch;
    pc_resp_nxt    = pc_resp;
    resp_valid_nxt = resp_valid;
    misalign_nxt   = misalign_q;
    count_nxt      = fetch_count + {31'd0, resp_valid && !bus.stall};

    if (rst)
      bus.imem_addr = RESET_PC;
    else if (redir_take)
      bus.imem_addr = {bus.redirect_target[31:2], 2'b00};
    else if (bus.stall || state == rv_pkg::S_TRAP)
      bus.imem_addr = pc_resp;
    else
      bus.imem_addr = pc_fetch;

    case (state)
      rv_pkg::S_BOOT: begin
        pc_resp_nxt    = RESET_PC;
        pc_fetch_nxt   = RESET_PC + 32'd4;
        resp_valid_nxt = 1'b1;
        misalign_nxt   = 1'b0;
        state_nxt      = rv_pkg::S_RUN;
      end
      default: begin
        if (redir_take) begin
          pc_resp_nxt    = bus.redirect_target;
          resp_valid_nxt = 1'b1;
          if (redir_mis) begin
            misalign_nxt = 1'b1;
            state_nxt    = rv_pkg::S_TRAP;
          end else begin
            pc_fetch_nxt = bus.redirect_target + 32'd4;
            misalign_nxt = 1'b0;
            state_nxt    = rv_pkg::S_RUN;
          end
        end else if (state == rv_pkg::S_TRAP) begin
          // Trap entry is shown once; after decode accepts it, fetch freezes.
          if (!bus.stall) begin
            resp_valid_nxt = 1'b0;
            misalign_nxt   = 1'b0;
          end
        end else if (!bus.stall) begin
          pc_resp_nxt    = pc_fetch;
          pc_fetch_nxt   = pc_fetch + 32'd4;
          resp_valid_nxt = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= rv_pkg::S_BOOT;
      pc_fetch    <= RESET_PC;
      pc_resp     <= RESET_PC;
      resp_valid  <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc_fetch    <= pc_fetch_nxt;
      pc_resp     <= pc_resp_nxt;
      resp_valid  <= resp_valid_nxt;
      misalign_q  <= misalign_nxt;
      fetch_count <= count_nxt;
    end
  end

  assign bus.id_pc       = pc_resp;
  assign bus.id_pc_plus4 = pc_resp + 32'd4;
  assign bus.id_valid    = resp_valid;
  assign bus.id_misalign = misalign_q;
  assign bus.id_instr    = (resp_valid && !misalign_q) ? bus.imem_rdata : NOP_INSTR;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus a randomized run against a
// transaction-level model of the fetch stream.
module tb_if_fetch_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_count;
  int          n_checks = 0;
  int          n_fail   = 0;

  if_fetch_stage_if bus();

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory, 1024 words.
  logic [31:0] mem [1024];
  always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[11:2]];

  // Reference model: the stream of (pc, valid, exception) handed to decode.
  bit          m_boot, m_trap, m_valid, m_mis;
  logic [31:0] m_pc, m_next, m_cnt;

  function automatic logic [31:0] exp_instr();
    return (m_valid && !m_mis) ? mem[m_pc[11:2]] : NOP_INSTR;
  endfunction

  function automatic logic [31:0] exp_addr();
    if (rst) return 32'h0;
    if (bus.redirect_valid && !m_boot) return bus.redirect_target & 32'hFFFF_FFFC;
    if (bus.stall || m_trap) return m_pc;
    return m_next;
  endfunction

  task automatic apply(input bit r, input bit s, input bit rv, input logic [31:0] t);
    rst                 = r;
    bus.stall           = s;
    bus.redirect_valid  = rv;
    bus.redirect_target = t;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_boot = 1; m_trap = 0; m_valid = 0; m_mis = 0;
      m_pc = 0; m_next = 0; m_cnt = 0;
    end else begin
      if (m_valid && !bus.stall) m_cnt = m_cnt + 1;
      if (m_boot) begin
        m_boot = 0; m_pc = 0; m_next = 4; m_valid = 1; m_mis = 0;
      end else if (bus.redirect_valid) begin
        m_pc = bus.redirect_target; m_valid = 1;
        if (bus.redirect_target[1:0] == 2'b00) begin
          m_next = bus.redirect_target + 4; m_mis = 0; m_trap = 0;
        end else begin
          m_mis = 1; m_trap = 1;
        end
      end else if (m_trap) begin
        if (!bus.stall) begin m_valid = 0; m_mis = 0; end
      end else if (!bus.stall) begin
        m_pc = m_next; m_next = m_next + 4; m_valid = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.id_valid); end
      n_checks++; if (bus.id_instr !== NOP_INSTR) begin n_fail++; $display("FAIL reset_instr got %h want %h", bus.id_instr, NOP_INSTR); end
      n_checks++; if (bus.id_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus.id_pc); end
      n_checks++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
      n_checks++; if (fetch_count !== 32'h0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    end
  endtask

  task automatic test_startup();
    apply(0, 0, 0, 32'h0);
    n_checks++; if (bus.id_instr !== NOP_INSTR || bus.id_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_nop got %h/%b want %h/0", bus.id_instr, bus.id_valid, NOP_INSTR); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL start_valid[%0d] got %b want 1", k, bus.id_valid); end
      n_checks++; if (bus.id_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL start_pc[%0d] got %h want %h", k, bus.id_pc, 32'(4 * k)); end
      n_checks++; if (bus.id_instr !== mem[k]) begin n_fail++; $display("FAIL start_instr[%0d] got %h want %h", k, bus.id_instr, mem[k]); end
      n_checks++; if (bus.id_pc_plus4 !== 32'(4 * k + 4)) begin n_fail++; $display("FAIL start_pc4[%0d] got %h want %h", k, bus.id_pc_plus4, 32'(4 * k + 4)); end
    end
    n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL start_count got %0d want 2", fetch_count); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 32'h0);
      n_checks++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr got %h want 8", bus.imem_addr); end
      step();
      n_checks++; if (bus.id_pc !== 32'h8) begin n_fail++; $display("FAIL stall_pc got %h want 8", bus.id_pc); end
      n_checks++; if (bus.id_instr !== mem[2]) begin n_fail++; $display("FAIL stall_instr got %h want %h", bus.id_instr, mem[2]); end
      n_checks++; if (fetch_count !== 32'd2) begin n_fail++; $display("FAIL stall_count got %0d want 2", fetch_count); end
    end
    apply(0, 0, 0, 32'h0);
    step();
    n_checks++; if (bus.id_pc !== 32'hC || bus.id_instr !== mem[3]) begin
      n_fail++; $display("FAIL unstall got %h/%h want c/%h", bus.id_pc, bus.id_instr, mem[3]); end
    n_checks++; if (fetch_count !== 32'd3) begin n_fail++; $display("FAIL unstall_count got %0d want 3", fetch_count); end
  endtask

  task automatic test_redirect();
    step();
    n_checks++; if (bus.id_pc !== 32'h10) begin n_fail++; $display("FAIL pre_redir_pc got %h want 10", bus.id_pc); end
    apply(0, 0, 1, 32'h100);
    n_checks++; if (bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr got %h want 100", bus.imem_addr); end
    step();
    n_checks++; if (bus.id_pc !== 32'h100 || bus.id_instr !== mem[64]) begin
      n_fail++; $display("FAIL redir got %h/%h want 100/%h", bus.id_pc, bus.id_instr, mem[64]); end
    apply(0, 0, 0, 32'h0);
    step();
    n_checks++; if (bus.id_pc !== 32'h104 || bus.id_instr !== mem[65]) begin
      n_fail++; $display("FAIL redir_next got %h/%h want 104/%h", bus.id_pc, bus.id_instr, mem[65]); end
  endtask

  task automatic test_misalign();
    apply(0, 0, 1, 32'h102);
    step();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_misalign !== 1'b1) begin
      n_fail++; $display("FAIL mis_flags got v=%b m=%b want v=1 m=1", bus.id_valid, bus.id_misalign); end
    n_checks++; if (bus.id_instr !== NOP_INSTR || bus.id_pc !== 32'h102) begin
      n_fail++; $display("FAIL mis_word got %h/%h want %h/102", bus.id_instr, bus.id_pc, NOP_INSTR); end
    apply(0, 1, 0, 32'h0);
    step();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_misalign !== 1'b1) begin
      n_fail++; $display("FAIL mis_stall got v=%b m=%b want v=1 m=1", bus.id_valid, bus.id_misalign); end
    apply(0, 0, 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL trap_hold[%0d] got %b want 0", i, bus.id_valid); end
    end
    apply(0, 0, 1, 32'h200);
    step();
    n_checks++; if (bus.id_pc !== 32'h200 || bus.id_misalign !== 1'b0 || bus.id_valid !== 1'b1) begin
      n_fail++; $display("FAIL trap_exit got %h m=%b v=%b want 200 m=0 v=1", bus.id_pc, bus.id_misalign, bus.id_valid); end
    n_checks++; if (bus.id_instr !== mem[128]) begin n_fail++; $display("FAIL trap_exit_instr got %h want %h", bus.id_instr, mem[128]); end
  endtask

  task automatic test_redirect_stall();
    apply(0, 1, 1, 32'h40);
    step();
    n_checks++; if (bus.id_pc !== 32'h40 || bus.id_instr !== mem[16]) begin
      n_fail++; $display("FAIL redir_stall got %h/%h want 40/%h", bus.id_pc, bus.id_instr, mem[16]); end
  endtask

  task automatic test_random();
    logic [31:0] t;
    bit r, s, rv;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 30);
      rv = ($urandom_range(0, 99) < 15);
      case ($urandom_range(0, 7))
        0:       t = {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
        1:       t = 32'hFFFF_FFFC;
        default: t = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      endcase
      apply(r, s, rv, t);
      n_checks++; if (bus.imem_addr !== exp_addr()) begin
        n_fail++; $display("FAIL rnd_addr[%0d] got %h want %h", i, bus.imem_addr, exp_addr()); end
      step();
      n_checks++; if (bus.id_valid !== m_valid || bus.id_pc !== m_pc) begin
        n_fail++; $display("FAIL rnd_pc[%0d] got v=%b %h want v=%b %h", i, bus.id_valid, bus.id_pc, m_valid, m_pc); end
      n_checks++; if (bus.id_instr !== exp_instr()) begin
        n_fail++; $display("FAIL rnd_instr[%0d] got %h want %h", i, bus.id_instr, exp_instr()); end
      n_checks++; if (m_valid && bus.id_misalign !== m_mis) begin
        n_fail++; $display("FAIL rnd_mis[%0d] got %b want %b", i, bus.id_misalign, m_mis); end
      n_checks++; if (bus.id_pc_plus4 !== m_pc + 32'd4) begin
        n_fail++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, bus.id_pc_plus4, m_pc + 32'd4); end
      n_checks++; if (fetch_count !== m_cnt) begin
        n_fail++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, fetch_count, m_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    apply(0, 0, 0, 32'h0);
    step();
    apply(1, 0, 1, 32'h300);
    step();
    n_checks++; if (bus.id_valid !== 1'b0 || fetch_count !== 32'd0 || bus.id_pc !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst got v=%b c=%0d pc=%h want v=0 c=0 pc=0", bus.id_valid, fetch_count, bus.id_pc); end
    apply(0, 0, 0, 32'h0);
    step();
    n_checks++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0 || bus.id_instr !== mem[0]) begin
      n_fail++; $display("FAIL mid_restart got v=%b %h/%h want v=1 0/%h", bus.id_valid, bus.id_pc, bus.id_instr, mem[0]); end
    step();
    n_checks++; if (bus.id_pc !== 32'h4 || fetch_count !== 32'd1) begin
      n_fail++; $display("FAIL mid_next got %h c=%0d want 4 c=1", bus.id_pc, fetch_count); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    m_boot = 1; m_trap = 0; m_valid = 0; m_mis = 0; m_pc = 0; m_next = 0; m_cnt = 0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_misalign();
    test_redirect_stall();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
